mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ACK_TIMEOUT, default 255, cycles in ACCESS without mem_ack before bus error is declared.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 ex_valid  input  1  EX/MEM slot holds a valid instruction.
REQ-005 ex_aluop  input  8  operation; load/store codes LB, LBU, LH, LHU, LW, SB, SH, SW; any other code is non-memory.
REQ-006 ex_wd  input  5  destination register index.
REQ-007 ex_wreg  input  1  instruction writes destination register.
REQ-008 ex_wdata  input  32  ALU result (non-memory write-back value).
REQ-009 ex_mem_addr  input  32  effective address.
REQ-010 ex_store_data  input  32  store source register value.
REQ-011 stall_req  output  1  hold EX/MEM inputs stable; upstream freezes while high.
REQ-012 mem_req, mem_we  output  1 each  data-bus request, write strobe.
REQ-013 mem_addr  output  32  word address (low two bits forced 0).
REQ-014 mem_sel  output  4  byte enables, big-endian (bit 3 = byte at offset 0).
REQ-015 mem_wdata  output  32  store data replicated to selected lanes.
REQ-016 mem_ack  input  1;  mem_rdata  input  32  response strobe and read data, valid in ack cycle.
REQ-017 wb_we  output  1;  wb_waddr  output  5;  wb_wdata  output  32  regfile write port.
REQ-018 addr_err, bus_err  output  1 each  one-cycle error pulses.

Function
REQ-019 FSM states IDLE and ACCESS only.
REQ-020 IDLE, ex_valid, non-memory op: wb_we<=ex_wreg and (ex_wd!=0), wb_waddr<=ex_wd, wb_wdata<=ex_wdata at next edge; latency 1; stall_req 0.
REQ-021 IDLE, ex_valid, aligned load/store: register mem_req=1, mem_we (1 for stores), mem_addr, mem_sel, mem_wdata, capture op/ex_wd/offset; go ACCESS; stall_req=1 combinationally in this cycle.
REQ-022 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; byte ops always aligned.
REQ-023 Misaligned: no request; addr_err pulse next cycle; wb_we=0; stay IDLE; stall_req 0.
REQ-024 mem_sel: byte offset n -> 4'b1000>>n; halfword offset 0 -> 1100, offset 2 -> 0011; word -> 1111.
REQ-025 mem_wdata: SB byte replicated to all 4 lanes; SH halfword replicated twice; SW unchanged.
REQ-026 ACCESS: mem_req and bus outputs held constant until mem_ack; stall_req=1 except in the ack cycle.
REQ-027 Ack cycle: stall_req=0; next edge: mem_req=0, state IDLE, load result written (wb_we=1 if ex_wd!=0), store gives wb_we=0.
REQ-028 Load extraction from selected lane: LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
REQ-029 Timeout counter: cleared on ACCESS entry, increments each ACCESS cycle; at ACK_TIMEOUT without ack: mem_req=0, bus_err pulse, wb_we=0, IDLE.
REQ-030 Ack and timeout in same cycle: ack wins, no bus_err.
REQ-031 mem_ack in IDLE ignored.
REQ-032 wb_we, addr_err, bus_err default 0 in any cycle not producing a result; ex_valid=0 produces wb_we=0.
REQ-033 Writes to register 0 never issue wb_we=1.

Reset
REQ-034 rst high at an edge: state IDLE, mem_req=0, mem_we=0, mem_sel=0, mem_addr=0, mem_wdata=0, wb_we=0, wb_waddr=0, wb_wdata=0, addr_err=0, bus_err=0, counter=0.
REQ-035 Reset mid-ACCESS abandons transaction; no write-back; later ack ignored.
REQ-036 stall_req=0 while rst high.

Structure
REQ-037 Load/store aluop codes, ZeroWord, RegBus, RegAddrBus, and Enable/Disable constants live in shared defines.v.
REQ-038 One sub-module, mem_align: combinational mem_sel/mem_wdata generation and load extract/extend.

Verification
REQ-039 ADD result 0x0000_1234 to r5 -> next cycle wb_we=1, wb_waddr=5, wb_wdata=0x0000_1234, no stall.
REQ-040 LB addr 0x101, mem_rdata 0x11A2_3344, ack after 3 cycles -> mem_sel=0100, wb_wdata=0xFFFF_FFA2, stall_req high 3 cycles.
REQ-041 SH addr 0x202 data 0x0000_BEEF -> mem_sel=0011, mem_wdata=0xBEEF_BEEF, mem_we=1, wb_we=0 after ack.
REQ-042 LW addr 0x103 -> addr_err pulse, mem_req stays 0, wb_we=0.
REQ-043 LW, no ack, ACK_TIMEOUT=4 -> bus_err after 4 ACCESS cycles, mem_req drops; ack at cycle 4 instead -> write-back, no bus_err.
REQ-044 rst during ACCESS, then ack -> mem_req=0, no wb_we, state IDLE.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM stage.
// Load/store op codes, bus widths, FSM state type, op classifiers.
package mem_stage_pkg;

  localparam int REG_W  = 32;
  localparam int ADDR_W = 5;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;

  localparam logic [7:0] OP_LB  = 8'hE0;
  localparam logic [7:0] OP_LH  = 8'hE1;
  localparam logic [7:0] OP_LW  = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4;
  localparam logic [7:0] OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8;
  localparam logic [7:0] OP_SH  = 8'hE9;
  localparam logic [7:0] OP_SW  = 8'hEB;
  localparam logic [7:0] OP_ADD = 8'h20;

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  function automatic logic is_load_op(
    input logic [7:0] op
  );
    return (op == OP_LB)  || (op == OP_LBU) ||
           (op == OP_LH)  || (op == OP_LHU) ||
           (op == OP_LW);
  endfunction

  function automatic logic is_store_op(
    input logic [7:0] op
  );
    return (op == OP_SB) || (op == OP_SH) ||
           (op == OP_SW);
  endfunction

  function automatic logic is_mem_op(
    input logic [7:0] op
  );
    return is_load_op(op) || is_store_op(op);
  endfunction

endpackage

// File: rtl/mem_stage_align.sv
// Byte-lane steering: request-side enables/store data and
// response-side load extract/extend. Big-endian lanes. Combinational.
module mem_stage_align
  import mem_stage_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  off,
  input  logic [31:0] sdata,
  input  logic [7:0]  ld_op,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic        misal,
  output logic [3:0]  sel,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  logic byte_op;
  logic half_op;
  logic word_op;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign byte_op = (op == OP_LB) || (op == OP_LBU) ||
                   (op == OP_SB);
  assign half_op = (op == OP_LH) || (op == OP_LHU) ||
                   (op == OP_SH);
  assign word_op = (op == OP_LW) || (op == OP_SW);

  always_comb begin
    sel   = 4'b0000;
    wdata = sdata;
    misal = 1'b0;
    unique case (1'b1)
      byte_op: begin
        sel   = 4'b1000 >> off;
        wdata = {4{sdata[7:0]}};
      end
      half_op: begin
        sel   = off[1] ? 4'b0011 : 4'b1100;
        wdata = {2{sdata[15:0]}};
        misal = off[0];
      end
      word_op: begin
        sel   = 4'b1111;
        misal = |off;
      end
      default: ;
    endcase
  end

  always_comb begin
    lane_b = rdata[31:24];
    unique case (ld_off)
      2'd0: lane_b = rdata[31:24];
      2'd1: lane_b = rdata[23:16];
      2'd2: lane_b = rdata[15:8];
      2'd3: lane_b = rdata[7:0];
      default: ;
    endcase
  end

  assign lane_h = ld_off[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    ld_data = rdata;
    unique case (1'b1)
      ld_op == OP_LB:
        ld_data = {{24{lane_b[7]}}, lane_b};
      ld_op == OP_LBU:
        ld_data = {24'h0, lane_b};
      ld_op == OP_LH:
        ld_data = {{16{lane_h[15]}}, lane_h};
      ld_op == OP_LHU:
        ld_data = {16'h0, lane_h};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: single outstanding data-bus access, write-back.
// EX/MEM slot in, data bus out, regfile write port and error pulses out.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [7:0]  ex_aluop,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_mem_addr,
  input  logic [31:0] ex_store_data,
  output logic        stall_req,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_sel,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        addr_err,
  output logic        bus_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [7:0]  op_q, op_n;
  logic [4:0]  wd_q, wd_n;
  logic [1:0]  off_q, off_n;

  logic        req_n, we_n;
  logic [31:0] addr_n, mwd_n;
  logic [3:0]  sel_n;
  logic        wbwe_n;
  logic [4:0]  wba_n;
  logic [31:0] wbd_n;
  logic        aerr_n, berr_n;
  logic        stall;

  logic        misal;
  logic [3:0]  a_sel;
  logic [31:0] a_wdata;
  logic [31:0] ld_data;

  mem_stage_align u_align (
    .op      (ex_aluop),
    .off     (ex_mem_addr[1:0]),
    .sdata   (ex_store_data),
    .ld_op   (op_q),
    .ld_off  (off_q),
    .rdata   (mem_rdata),
    .misal   (misal),
    .sel     (a_sel),
    .wdata   (a_wdata),
    .ld_data (ld_data)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    op_n    = op_q;
    wd_n    = wd_q;
    off_n   = off_q;
    req_n   = mem_req;
    we_n    = mem_we;
    addr_n  = mem_addr;
    sel_n   = mem_sel;
    mwd_n   = mem_wdata;
    wbwe_n  = DISABLE;
    wba_n   = wb_waddr;
    wbd_n   = wb_wdata;
    aerr_n  = DISABLE;
    berr_n  = DISABLE;
    stall   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (ex_valid) begin
          if (!is_mem_op(ex_aluop)) begin
            wbwe_n = ex_wreg && (ex_wd != 5'd0);
            wba_n  = ex_wd;
            wbd_n  = ex_wdata;
          end else if (misal) begin
            aerr_n = ENABLE;
          end else begin
            stall   = 1'b1;
            req_n   = ENABLE;
            we_n    = is_store_op(ex_aluop);
            addr_n  = {ex_mem_addr[31:2], 2'b00};
            sel_n   = a_sel;
            mwd_n   = a_wdata;
            op_n    = ex_aluop;
            wd_n    = ex_wd;
            off_n   = ex_mem_addr[1:0];
            cnt_n   = '0;
            state_n = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // ack beats a simultaneous timeout
        if (mem_ack) begin
          req_n   = DISABLE;
          we_n    = DISABLE;
          state_n = S_IDLE;
          if (is_load_op(op_q)) begin
            wbwe_n = (wd_q != 5'd0);
            wba_n  = wd_q;
            wbd_n  = ld_data;
          end
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          stall   = 1'b1;
          req_n   = DISABLE;
          we_n    = DISABLE;
          berr_n  = ENABLE;
          state_n = S_IDLE;
        end else begin
          stall = 1'b1;
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign stall_req = stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= 8'h00;
      wd_q      <= 5'd0;
      off_q     <= 2'd0;
      mem_req   <= DISABLE;
      mem_we    <= DISABLE;
      mem_addr  <= ZERO_WORD;
      mem_sel   <= 4'b0000;
      mem_wdata <= ZERO_WORD;
      wb_we     <= DISABLE;
      wb_waddr  <= 5'd0;
      wb_wdata  <= ZERO_WORD;
      addr_err  <= DISABLE;
      bus_err   <= DISABLE;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      op_q      <= op_n;
      wd_q      <= wd_n;
      off_q     <= off_n;
      mem_req   <= req_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_sel   <= sel_n;
      mem_wdata <= mwd_n;
      wb_we     <= wbwe_n;
      wb_waddr  <= wba_n;
      wb_wdata  <= wbd_n;
      addr_err  <= aerr_n;
      bus_err   <= berr_n;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: transaction-level reference model,
// per-cycle compare, directed literal cases, randomized traffic.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [7:0]  ex_aluop;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic [31:0] ex_mem_addr;
  logic [31:0] ex_store_data;
  logic        stall_req;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_sel;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        addr_err, bus_err;

  mem_stage #(.ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .ex_wdata(ex_wdata), .ex_mem_addr(ex_mem_addr),
    .ex_store_data(ex_store_data),
    .stall_req(stall_req),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_sel(mem_sel),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit go = 0;

  // reference model: one pending transaction record
  bit          pend;
  logic [7:0]  p_op;
  logic [4:0]  p_wd;
  int          p_off;
  int          p_age;
  logic        e_req, e_we, e_wbwe, e_aerr, e_berr;
  logic [31:0] e_addr, e_mwd, e_wbd;
  logic [3:0]  e_sel;
  logic [4:0]  e_wba;

  function automatic int op_size(input logic [7:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH)
      return 2;
    return 1;
  endfunction

  function automatic logic [3:0] m_sel(
    input int sz, input int off);
    int v;
    v = ((1 << sz) - 1) << (4 - sz - off);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(
    input int sz, input logic [31:0] d);
    if (sz == 1) return {24'h0, d[7:0]} * 32'h0101_0101;
    if (sz == 2) return {16'h0, d[15:0]} * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(
    input logic [7:0] op, input int off,
    input logic [31:0] rd);
    int sz;
    longint v, half;
    sz = op_size(op);
    v = longint'(rd >> (8 * (4 - sz - off)));
    v = v % (64'd1 << (8 * sz));
    half = 64'd1 << (8 * sz - 1);
    if ((op == OP_LB || op == OP_LH) && v >= half)
      v = v - (half * 2);
    return v[31:0];
  endfunction

  function automatic bit m_stall();
    if (rst) return 0;
    if (pend) return !mem_ack;
    return ex_valid && is_mem_op(ex_aluop) &&
      (ex_mem_addr % op_size(ex_aluop) == 0);
  endfunction

  task automatic model_step();
    e_wbwe = 0;
    e_aerr = 0;
    e_berr = 0;
    if (rst) begin
      pend = 0;
      e_req = 0; e_we = 0; e_addr = 0;
      e_sel = 0; e_mwd = 0; e_wba = 0; e_wbd = 0;
    end else if (!pend) begin
      if (ex_valid && !is_mem_op(ex_aluop)) begin
        e_wbwe = ex_wreg && ex_wd != 0;
        e_wba = ex_wd;
        e_wbd = ex_wdata;
      end else if (ex_valid) begin
        if (ex_mem_addr % op_size(ex_aluop) != 0) begin
          e_aerr = 1;
        end else begin
          pend = 1;
          p_op = ex_aluop;
          p_wd = ex_wd;
          p_off = int'(ex_mem_addr % 4);
          p_age = 0;
          e_req = 1;
          e_we = is_store_op(ex_aluop);
          e_addr = ex_mem_addr - (ex_mem_addr % 4);
          e_sel = m_sel(op_size(ex_aluop), p_off);
          e_mwd = m_wdata(op_size(ex_aluop), ex_store_data);
        end
      end
    end else begin
      p_age++;
      if (mem_ack) begin
        pend = 0;
        e_req = 0;
        e_we = 0;
        if (is_load_op(p_op)) begin
          e_wbwe = p_wd != 0;
          e_wba = p_wd;
          e_wbd = m_load(p_op, p_off, mem_rdata);
        end
      end else if (p_age == TO) begin
        pend = 0;
        e_req = 0;
        e_we = 0;
        e_berr = 1;
      end
    end
  endtask

  task automatic chk(input string nm,
    input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h t=%0t",
        nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
  endtask

  always @(negedge clk) begin
    if (go) begin
      chk("stall_req", 32'(stall_req), 32'(m_stall()));
      chk("mem_req", 32'(mem_req), 32'(e_req));
      chk("wb_we", 32'(wb_we), 32'(e_wbwe));
      chk("addr_err", 32'(addr_err), 32'(e_aerr));
      chk("bus_err", 32'(bus_err), 32'(e_berr));
      if (e_req) begin
        chk("mem_we", 32'(mem_we), 32'(e_we));
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_sel", 32'(mem_sel), 32'(e_sel));
        chk("mem_wdata", mem_wdata, e_mwd);
      end
      if (e_wbwe) begin
        chk("wb_waddr", 32'(wb_waddr), 32'(e_wba));
        chk("wb_wdata", wb_wdata, e_wbd);
      end
    end
  end

  task automatic idle_in();
    ex_valid = 0; ex_aluop = OP_ADD; ex_wd = 0;
    ex_wreg = 0; ex_wdata = 0; ex_mem_addr = 0;
    ex_store_data = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic put(input logic [7:0] op,
    input logic [31:0] a, input logic [4:0] wd,
    input logic [31:0] d);
    ex_valid = 1; ex_aluop = op; ex_mem_addr = a;
    ex_wd = wd; ex_wreg = 1; ex_store_data = d;
    ex_wdata = d;
  endtask

  logic [7:0] ops [10];
  int hold_n;
  bit hold;

  initial begin
    ops = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW,
            OP_SB, OP_SH, OP_SW, OP_ADD, 8'h25};
    pend = 0;
    rst = 1;
    idle_in();
    tick();
    tick();
    chk("rst mem_req", 32'(mem_req), 0);
    chk("rst mem_sel", 32'(mem_sel), 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst wb_we", 32'(wb_we), 0);
    chk("rst wb_waddr", 32'(wb_waddr), 0);
    chk("rst wb_wdata", wb_wdata, 0);
    chk("rst stall", 32'(stall_req), 0);
    go = 1;
    rst = 0;
    tick();

    // ADD r5
    put(OP_ADD, 32'h0, 5'd5, 32'h0000_1234);
    #1 chk("add stall", 32'(stall_req), 0);
    tick();
    idle_in();
    chk("add wb_we", 32'(wb_we), 1);
    chk("add waddr", 32'(wb_waddr), 5);
    chk("add wdata", wb_wdata, 32'h0000_1234);

    // ADD to r0
    put(OP_ADD, 32'h0, 5'd0, 32'h55);
    tick();
    idle_in();
    chk("r0 wb_we", 32'(wb_we), 0);

    // LB 0x101, ack in third stalled cycle
    put(OP_LB, 32'h101, 5'd7, 32'h0);
    mem_rdata = 32'h11A2_3344;
    hold_n = 0;
    #1 hold_n += int'(stall_req);
    tick();
    chk("lb mem_sel", 32'(mem_sel), 32'h4);
    chk("lb mem_addr", mem_addr, 32'h100);
    chk("lb mem_we", 32'(mem_we), 0);
    #1 hold_n += int'(stall_req);
    tick();
    #1 hold_n += int'(stall_req);
    tick();
    mem_ack = 1;
    #1 hold_n += int'(stall_req);
    chk("lb ack stall", 32'(stall_req), 0);
    tick();
    idle_in();
    chk("lb stall cycles", 32'(hold_n), 3);
    chk("lb wb_we", 32'(wb_we), 1);
    chk("lb wdata", wb_wdata, 32'hFFFF_FFA2);
    chk("lb req drop", 32'(mem_req), 0);

    // SH 0x202
    put(OP_SH, 32'h202, 5'd3, 32'h0000_BEEF);
    tick();
    chk("sh mem_sel", 32'(mem_sel), 32'h3);
    chk("sh mem_wdata", mem_wdata, 32'hBEEF_BEEF);
    chk("sh mem_we", 32'(mem_we), 1);
    mem_ack = 1;
    tick();
    idle_in();
    chk("sh wb_we", 32'(wb_we), 0);

    // LW 0x103 misaligned
    put(OP_LW, 32'h103, 5'd4, 32'h0);
    #1 chk("lw mis stall", 32'(stall_req), 0);
    tick();
    idle_in();
    chk("lw addr_err", 32'(addr_err), 1);
    chk("lw mis req", 32'(mem_req), 0);
    chk("lw mis wb_we", 32'(wb_we), 0);
    tick();
    chk("addr_err pulse", 32'(addr_err), 0);

    // LW timeout
    put(OP_LW, 32'h400, 5'd9, 32'h0);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to req held", 32'(mem_req), 1);
    chk("to no berr", 32'(bus_err), 0);
    tick();
    idle_in();
    chk("to bus_err", 32'(bus_err), 1);
    chk("to req drop", 32'(mem_req), 0);
    chk("to wb_we", 32'(wb_we), 0);
    tick();

    // LW ack in last allowed cycle
    put(OP_LW, 32'h400, 5'd9, 32'h0);
    mem_rdata = 32'hCAFE_BABE;
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    mem_ack = 1;
    tick();
    idle_in();
    chk("late ack wb_we", 32'(wb_we), 1);
    chk("late ack data", wb_wdata, 32'hCAFE_BABE);
    chk("late ack berr", 32'(bus_err), 0);

    // reset mid-access then stale ack
    put(OP_LW, 32'h800, 5'd6, 32'h0);
    tick();
    tick();
    rst = 1;
    idle_in();
    #1 chk("rst stall", 32'(stall_req), 0);
    tick();
    rst = 0;
    mem_ack = 1;
    mem_rdata = 32'h1234_5678;
    tick();
    idle_in();
    chk("stale ack wb_we", 32'(wb_we), 0);
    chk("stale ack req", 32'(mem_req), 0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      hold = m_stall();
      tick();
      rst = ($urandom_range(0, 299) == 0);
      mem_rdata = $urandom;
      if (pend)
        mem_ack = ($urandom_range(0, 2) == 0);
      else
        mem_ack = ($urandom_range(0, 3) == 0);
      if (!hold) begin
        ex_valid = ($urandom_range(0, 4) != 0);
        ex_aluop = ops[$urandom_range(0, 9)];
        ex_wd = ($urandom_range(0, 5) == 0) ?
                5'd0 : 5'($urandom);
        ex_wreg = $urandom_range(0, 3) != 0;
        ex_wdata = $urandom;
        ex_mem_addr = $urandom;
        ex_store_data = $urandom;
      end
    end

    rst = 0;
    idle_in();
    tick();
    tick();
    go = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
      n_cmp, n_bad);
    $finish;
  end

endmodule
